// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared types and constants for the colour-zone detector:
//   colour_t  - colour selector (RED, GREEN, BLUE, WHITE), same encoding as
//               the 2-bit color_mode input
//   state_t   - frame FSM states
//   rgb_t     - 12-bit pixel split into 4-bit channels {R,G,B}
//   *_GT/*_LT - per-colour channel thresholds (strict compares)
//   NO_COLOR  - operate_mode value when no zone qualifies
// -----------------------------------------------------------------------------
package cam_pkg;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2,
        WHITE = 2'd3
    } colour_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Channel thresholds; GT means channel > value, LT means channel < value.
    localparam logic [3:0] RED_R_GT   = 4'd6;
    localparam logic [3:0] RED_G_LT   = 4'd3;
    localparam logic [3:0] RED_B_LT   = 4'd3;
    localparam logic [3:0] GREEN_R_LT = 4'd4;
    localparam logic [3:0] GREEN_G_GT = 4'd6;
    localparam logic [3:0] GREEN_B_LT = 4'd4;
    localparam logic [3:0] BLUE_R_LT  = 4'd5;
    localparam logic [3:0] BLUE_G_LT  = 4'd5;
    localparam logic [3:0] BLUE_B_GT  = 4'd6;
    localparam logic [3:0] WHITE_GT   = 4'd11;

    localparam int NO_COLOR = 0;

endpackage

// File: rtl/cam_pixel_classify.sv
// -----------------------------------------------------------------------------
// cam_pixel_classify
// Combinational pixel classifier: tells whether a 12-bit RGB pixel belongs to
// the selected colour. Shared with the debug overlay.
// Ports:
//   pix_data  in  12  {R[11:8],G[7:4],B[3:0]}
//   colour    in  colour_t  colour under test
//   match     out 1   pixel matches colour
// -----------------------------------------------------------------------------
module cam_pixel_classify
    import cam_pkg::*;
(
    input  logic [11:0] pix_data,
    input  colour_t     colour,
    output logic        match
);

    rgb_t px;
    assign px = rgb_t'(pix_data);

    always_comb begin
        // NOTE: default assignment first so every path drives match; no latch.
        match = 1'b0;
        case (colour)
            RED:   match = (px.r > RED_R_GT)   && (px.g < RED_G_LT)   && (px.b < RED_B_LT);
            GREEN: match = (px.r < GREEN_R_LT) && (px.g > GREEN_G_GT) && (px.b < GREEN_B_LT);
            BLUE:  match = (px.r < BLUE_R_LT)  && (px.g < BLUE_G_LT)  && (px.b > BLUE_B_GT);
            WHITE: match = (px.r > WHITE_GT)   && (px.g > WHITE_GT)   && (px.b > WHITE_GT);
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/cam_zone_detect.sv
// -----------------------------------------------------------------------------
// cam_zone_detect
// Streaming colour-zone detector. Counts pixels of the selected colour in
// N_ZONES equal column bands and, once per frame, publishes the winning band.
// Ports:
//   clk           in   1        system clock
//   reset         in   1        synchronous, active-high reset
//   pix_valid     in   1        pixel accepted when high
//   pix_sof       in   1        first pixel of a frame (with pix_valid)
//   pix_data      in   12       {R,G,B} 4 bits each
//   color_mode    in   2        colour_t, sampled on the SOF pixel
//   operate_mode  out  N_ZONES  one-hot winner, MSB = leftmost zone, 0 = none
//   win_count     out  CNT_W    matching-pixel count of the winner
//   frame_done    out  1        one-cycle pulse when results update
//   frame_err     out  1        sticky protocol error flag
// -----------------------------------------------------------------------------
module cam_zone_detect
    import cam_pkg::*;
#(
    parameter  int IMG_W     = 320,
    parameter  int IMG_H     = 240,
    parameter  int N_ZONES   = 3,
    parameter  int MIN_COUNT = 64,
    localparam int CNT_W     = $clog2(IMG_W * IMG_H + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic               pix_sof,
    input  logic [11:0]        pix_data,
    input  logic [1:0]         color_mode,
    output logic [N_ZONES-1:0] operate_mode,
    output logic [CNT_W-1:0]   win_count,
    output logic               frame_done,
    output logic               frame_err
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int ZW     = IMG_W / N_ZONES;
    localparam int CENTRE = N_ZONES / 2;
    localparam int IDX_W  = $clog2(N_ZONES + 1);

    state_t             state_q, state_d;
    logic               start, accum_px, pix_accept, err_set, do_scan, do_publish;
    colour_t            mode_q, cur_mode;
    logic [COL_W-1:0]   col_q, cur_col;
    logic [ROW_W-1:0]   row_q, cur_row;
    logic               pix_match, last_px;
    logic [N_ZONES-1:0] zone_hit;
    logic [CNT_W-1:0]   zone_cnt [N_ZONES];
    logic [IDX_W-1:0]   scan_q, scan_zone, best_idx_q, win_bit;
    logic [CNT_W-1:0]   best_cnt_q, scan_cnt;
    logic [N_ZONES-1:0] win_onehot;

    // An SOF pixel restarts the frame at (0,0) with the new colour, even while
    // a previous frame is still accumulating.
    assign pix_accept = start | accum_px;
    assign cur_col    = start ? '0 : col_q;
    assign cur_row    = start ? '0 : row_q;
    assign cur_mode   = start ? colour_t'(color_mode) : mode_q;
    assign last_px    = (cur_col == COL_W'(IMG_W - 1)) && (cur_row == ROW_W'(IMG_H - 1));

    cam_pixel_classify u_classify (
        .pix_data (pix_data),
        .colour   (cur_mode),
        .match    (pix_match)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (pix_accept) state_d = last_px ? COMPARE : ACCUM;
            COMPARE:     if (scan_q == IDX_W'(N_ZONES - 1)) state_d = PUBLISH;
            PUBLISH:     state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // ---------------- FSM: control outputs ----------------
    always_comb begin
        start      = 1'b0;
        accum_px   = 1'b0;
        err_set    = 1'b0;
        do_scan    = 1'b0;
        do_publish = 1'b0;
        case (state_q)
            IDLE: if (pix_valid) begin
                start   = pix_sof;
                err_set = !pix_sof;
            end
            ACCUM: if (pix_valid) begin
                start    = pix_sof;
                err_set  = pix_sof;
                accum_px = !pix_sof;
            end
            COMPARE: begin
                do_scan = 1'b1;
                err_set = pix_valid;
            end
            PUBLISH: begin
                do_publish = 1'b1;
                err_set    = pix_valid;
            end
            default: ;
        endcase
    end

    // ---------------- zone decode and counters ----------------
    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        localparam int LO = z * ZW;
        localparam int HI = (z + 1) * ZW;
        logic [CNT_W-1:0] cnt_q;
        logic             hit;

        // Boundary compares replace col/ZW; the last zone takes the remainder.
        if (N_ZONES == 1) begin : g_only
            assign zone_hit[z] = 1'b1;
        end else if (z == 0) begin : g_first
            assign zone_hit[z] = cur_col < COL_W'(HI);
        end else if (z == N_ZONES - 1) begin : g_last
            assign zone_hit[z] = cur_col >= COL_W'(LO);
        end else begin : g_mid
            assign zone_hit[z] = (cur_col >= COL_W'(LO)) && (cur_col < COL_W'(HI));
        end

        assign hit = pix_match & zone_hit[z];

        // NOTE: per-zone counters are individual flops, not a memory array, so
        // they take the synchronous reset like any other register.
        always_ff @(posedge clk) begin
            if (reset)
                cnt_q <= '0;
            else if (start)
                cnt_q <= hit ? CNT_W'(1) : '0;
            else if (accum_px && hit && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end

        assign zone_cnt[z] = cnt_q;
    end

    // ---------------- arg-max scan ----------------
    // Step 0 loads the centre zone; later steps walk the other zones in
    // increasing index, skipping the centre. Strict '>' keeps ties with the
    // incumbent, which gives the centre priority, then the lower index.
    always_comb begin
        scan_zone = IDX_W'(CENTRE);
        if (scan_q != '0)
            scan_zone = ((scan_q - 1'b1) < IDX_W'(CENTRE)) ? scan_q - 1'b1 : scan_q;
    end

    assign scan_cnt   = zone_cnt[scan_zone];
    assign win_bit    = IDX_W'(N_ZONES - 1) - best_idx_q;
    assign win_onehot = N_ZONES'(1) << win_bit;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= RED;
            scan_q       <= '0;
            best_idx_q   <= '0;
            best_cnt_q   <= '0;
            operate_mode <= '0;
            win_count    <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            if (start) mode_q <= cur_mode;

            if (pix_accept) begin
                if (cur_col == COL_W'(IMG_W - 1)) begin
                    col_q <= '0;
                    row_q <= cur_row + 1'b1;
                end else begin
                    col_q <= cur_col + 1'b1;
                    row_q <= cur_row;
                end
            end

            scan_q <= do_scan ? scan_q + 1'b1 : '0;
            if (do_scan && ((scan_q == '0) || (scan_cnt > best_cnt_q))) begin
                best_cnt_q <= scan_cnt;
                best_idx_q <= scan_zone;
            end

            if (err_set) frame_err <= 1'b1;

            frame_done <= 1'b0;
            if (do_publish) begin
                win_count    <= best_cnt_q;
                operate_mode <= (best_cnt_q >= CNT_W'(MIN_COUNT)) ? win_onehot
                                                                 : N_ZONES'(NO_COLOR);
                frame_done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_zone_detect.sv
// -----------------------------------------------------------------------------
// tb_cam_zone_detect
// Self-checking bench. Instance A keeps the 320-column geometry with a short
// frame; instance B uses 5 zones over 322 columns. Both share the input bus.
// -----------------------------------------------------------------------------
module tb_cam_zone_detect;
    import cam_pkg::*;

    localparam int AW = 320, AH = 6, AN = 3, AMIN = 64;
    localparam int BW = 322, BH = 4, BN = 5, BMIN = 64;
    localparam int ACW = $clog2(AW * AH + 1);
    localparam int BCW = $clog2(BW * BH + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid, pix_sof;
    logic [11:0] pix_data;
    logic [1:0]  color_mode;

    logic [AN-1:0]  a_mode;
    logic [ACW-1:0] a_win;
    logic           a_done, a_err;
    logic [BN-1:0]  b_mode;
    logic [BCW-1:0] b_win;
    logic           b_done, b_err;

    always #5 clk = ~clk;

    cam_zone_detect #(.IMG_W(AW), .IMG_H(AH), .N_ZONES(AN), .MIN_COUNT(AMIN)) dut_a (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_data(pix_data), .color_mode(color_mode),
        .operate_mode(a_mode), .win_count(a_win), .frame_done(a_done), .frame_err(a_err)
    );

    cam_zone_detect #(.IMG_W(BW), .IMG_H(BH), .N_ZONES(BN), .MIN_COUNT(BMIN)) dut_b (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_data(pix_data), .color_mode(color_mode),
        .operate_mode(b_mode), .win_count(b_win), .frame_done(b_done), .frame_err(b_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;
    bit sel_b = 1'b0;

    always @(posedge clk) begin
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
    end

    logic [31:0] cur_mode, cur_win;
    logic        cur_done, cur_err;
    assign cur_mode = sel_b ? 32'(b_mode) : 32'(a_mode);
    assign cur_win  = sel_b ? 32'(b_win)  : 32'(a_win);
    assign cur_done = sel_b ? b_done : a_done;
    assign cur_err  = sel_b ? b_err  : a_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int exp_cnt [16];
    int rnd_p   [16];

    function automatic bit exp_match(logic [11:0] p, logic [1:0] m);
        int r, g, b;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        case (m)
            2'd0:    return (r > 6)  && (g < 3)  && (b < 3);
            2'd1:    return (r < 4)  && (g > 6)  && (b < 4);
            2'd2:    return (r < 5)  && (g < 5)  && (b > 6);
            default: return (r > 11) && (g > 11) && (b > 11);
        endcase
    endfunction

    function automatic int zone_of(int col, int w, int nz);
        int z;
        z = col / (w / nz);
        return (z > nz - 1) ? nz - 1 : z;
    endfunction

    task automatic model_result(input int nz, input int min_cnt, output int emode, output int ewin);
        int mx, winner;
        mx = 0;
        for (int z = 0; z < nz; z++) if (exp_cnt[z] > mx) mx = exp_cnt[z];
        winner = -1;
        if (exp_cnt[nz / 2] == mx) winner = nz / 2;
        for (int z = 0; z < nz; z++) if (winner < 0 && exp_cnt[z] == mx) winner = z;
        ewin  = mx;
        emode = (mx >= min_cnt) ? (1 << (nz - 1 - winner)) : 0;
    endtask

    function automatic logic [11:0] pixel_at(int kind, int col, int row, int w, int nz);
        case (kind)
            1: return (col >= 106 && col <= 211) ? 12'hF00 : 12'h000;
            2: return (col <= 9 && row <= 4) ? 12'h00F : 12'h000;
            3: return (col < 50 || (col >= 250 && col < 300)) ? 12'h0F0 : 12'h000;
            4: return (col < 50 || (col >= 110 && col < 160)) ? 12'h0F0 : 12'h000;
            5: return (col < 100) ? 12'hBBB : (col >= 300) ? 12'hCCC : 12'h000;
            6: return (col < 30) ? 12'h722 : (col >= 106 && col < 212) ? 12'h622 :
                      (col >= 212) ? 12'h732 : 12'h000;
            8: return (col >= 256) ? 12'hFFF : 12'h000;
            9: begin
                if ($urandom_range(99) < rnd_p[zone_of(col, w, nz)]) begin
                    case ($urandom_range(3))
                        0:       return 12'hF00;
                        1:       return 12'h0F0;
                        2:       return 12'h00F;
                        default: return 12'hFFF;
                    endcase
                end
                return 12'($urandom);
            end
            default: return 12'h000;
        endcase
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic send_pixels(input int w, input int nz, input int rows, input int kind,
                               input logic [1:0] mode, input int gap_pct);
        logic [11:0] px;
        for (int i = 0; i < 16; i++) exp_cnt[i] = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < w; c++) begin
                while (int'($urandom_range(99)) < gap_pct) begin
                    pix_valid  = 1'b0;
                    pix_sof    = 1'b0;
                    pix_data   = 12'($urandom);
                    color_mode = 2'($urandom);
                    @(posedge clk); #1;
                end
                px         = pixel_at(kind, c, r, w, nz);
                pix_valid  = 1'b1;
                pix_sof    = (r == 0 && c == 0);
                pix_data   = px;
                color_mode = pix_sof ? mode : 2'($urandom);
                if (exp_match(px, mode)) exp_cnt[zone_of(c, w, nz)]++;
                @(posedge clk); #1;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    // Called right after the last pixel; optionally pokes an SOF pixel into
    // COMPARE, then checks latency, result and single-cycle pulse.
    task automatic wait_publish(input string tag, input int nz, input int emode,
                                input int ewin, input bit poke);
        int lat;
        lat = 0;
        if (poke) begin
            pix_valid = 1'b1;
            pix_sof   = 1'b1;
            pix_data  = 12'hF00;
            @(posedge clk); #1;
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
            lat = 1;
        end
        while (!cur_done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, nz + 1);
        check({tag, " operate_mode"}, cur_mode, emode);
        check({tag, " win_count"}, cur_win, ewin);
        @(posedge clk); #1;
        check({tag, " done pulse width"}, 32'(cur_done), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic random_frame(input string tag, input int w, input int h, input int nz,
                                input int min_cnt, input int gap_pct, input bit poke);
        int em, ew;
        logic [1:0] m;
        m = 2'($urandom);
        for (int z = 0; z < nz; z++) rnd_p[z] = $urandom_range(40);
        send_pixels(w, nz, h, 9, m, gap_pct);
        model_result(nz, min_cnt, em, ew);
        wait_publish(tag, nz, em, ew, poke);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        int         kind;
        logic [1:0] mode;
        bit         poke;
        int         exp_mode;
        int         exp_win;
        bit         exp_err;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;

        tbl[0] = '{"red centre band",     1, 2'd0, 1'b0, 3'b010, 636, 1'b0};
        tbl[1] = '{"blue below min",      2, 2'd2, 1'b0, 3'b000, 50,  1'b0};
        tbl[2] = '{"green tie z0 z2",     3, 2'd1, 1'b0, 3'b100, 300, 1'b0};
        tbl[3] = '{"green tie z0 z1",     4, 2'd1, 1'b0, 3'b010, 300, 1'b0};
        tbl[4] = '{"white threshold",     5, 2'd3, 1'b0, 3'b001, 120, 1'b0};
        tbl[5] = '{"red threshold+poke",  6, 2'd0, 1'b1, 3'b100, 180, 1'b1};
        tbl[6] = '{"no match",            7, 2'd1, 1'b0, 3'b000, 0,   1'b1};

        reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; color_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset a operate_mode", 32'(a_mode), 0);
        check("reset a win_count",    32'(a_win),  0);
        check("reset a frame_done",   32'(a_done), 0);
        check("reset a frame_err",    32'(a_err),  0);
        check("reset b operate_mode", 32'(b_mode), 0);
        check("reset b frame_err",    32'(b_err),  0);
        reset = 1'b0;

        // Table-driven frames on instance A.
        sel_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_pixels(AW, AN, AH, tbl[i].kind, tbl[i].mode, 0);
            wait_publish(tbl[i].name, AN, tbl[i].exp_mode, tbl[i].exp_win, tbl[i].poke);
            check({tbl[i].name, " frame_err"}, 32'(a_err), 32'(tbl[i].exp_err));
            repeat (3) @(posedge clk);
            #1;
            check({tbl[i].name, " hold"}, 32'(a_mode), tbl[i].exp_mode);
        end

        // Stray pixel without SOF in IDLE.
        do_reset();
        check("err cleared by reset", 32'(a_err), 0);
        done_before = a_done_cnt;
        pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 12'hF00;
        @(posedge clk); #1;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        check("idle stray pixel err", 32'(a_err), 1);
        check("idle stray no done", a_done_cnt - done_before, 0);

        // SOF re-issued mid-frame aborts and restarts.
        do_reset();
        done_before = a_done_cnt;
        send_pixels(AW, AN, 3, 1, 2'd0, 0);
        check("partial frame no err", 32'(a_err), 0);
        send_pixels(AW, AN, AH, 1, 2'd0, 0);
        wait_publish("abort restart", AN, 3'b010, 636, 1'b0);
        check("abort err sticky", 32'(a_err), 1);
        check("abort single done", a_done_cnt - done_before, 1);

        // Five zones over 322 columns: last zone absorbs the remainder.
        do_reset();
        sel_b = 1'b1;
        send_pixels(BW, BN, BH, 8, 2'd3, 0);
        wait_publish("5 zone last", BN, 5'b00001, 264, 1'b0);
        random_frame("5 zone random", BW, BH, BN, BMIN, 30, 1'b0);
        sel_b = 1'b0;

        // Gapped frames, reset mid-frame, then model-checked frames.
        do_reset();
        random_frame("gap frame", AW, AH, AN, AMIN, 50, 1'b1);
        check("gap frame err", 32'(a_err), 1);
        done_before = a_done_cnt;
        for (int i = 0; i < 16; i++) rnd_p[i] = 30;
        send_pixels(AW, AN, 3, 9, 2'd0, 50);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid reset operate_mode", 32'(a_mode), 0);
        check("mid reset win_count",    32'(a_win),  0);
        check("mid reset frame_done",   32'(a_done), 0);
        check("mid reset frame_err",    32'(a_err),  0);
        reset = 1'b0;
        check("mid reset no done", a_done_cnt - done_before, 0);
        random_frame("post reset gap", AW, AH, AN, AMIN, 50, 1'b0);
        for (int k = 0; k < 3; k++) random_frame($sformatf("random %0d", k), AW, AH, AN, AMIN, 20, 1'b0);
        check("random frames no err", 32'(a_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
